rv32_ifu: RTL and testbench
===========================

RV32_IFU -- requirements
Module: rv32_ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, is the instruction buffer depth; legal values are 2 and 4.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port imem_req_o, output, 1: fetch request valid toward instruction ROM.
REQ-006 Port imem_ready_i, input, 1: ROM accepts the request this cycle.
REQ-007 Port imem_addr_o, output, 32: fetch address, word aligned.
REQ-008 Port imem_rvalid_i, input, 1: ROM returns read data this cycle.
REQ-009 Port imem_rdata_i, input, 32: instruction word returned by ROM.
REQ-010 Port redirect_i, input, 1: the EXU requests a PC change (taken branch or jump).
REQ-011 Port redirect_pc_i, input, 32: the new PC from the EXU.
REQ-012 Port instr_valid_o, output, 1: instr_o/pc_o are valid for the decoder.
REQ-013 Port instr_ready_i, input, 1: the decoder consumes the instruction this cycle.
REQ-014 Port instr_o, output, 32: instruction word at the FIFO head.
REQ-015 Port pc_o, output, 32: address of instr_o.
REQ-016 Port misalign_o, output, 1: the last redirect target was not word aligned; fetch is halted.

Function
REQ-017 The FSM SHALL have states RESET, FETCH, WAIT and HALT, encoded one-hot or binary.
REQ-018 Transitions out of RESET:
- RESET->FETCH on the first cycle with reset low.
REQ-019 Transitions out of FETCH:
- FETCH->WAIT when imem_req_o & imem_ready_i.
REQ-020 Transitions out of WAIT:
- WAIT->FETCH on imem_rvalid_i.
REQ-021 Transitions out of any state on redirect:
- Any state->HALT on redirect_i with redirect_pc_i[1:0]!=0.
- HALT->FETCH only on redirect_i with an aligned target.
REQ-022 At most one request SHALL be outstanding.
REQ-023 imem_req_o SHALL be asserted in FETCH only when (fifo_count + outstanding) < FIFO_DEPTH or a pop occurs this cycle.
REQ-024 imem_addr_o SHALL equal the fetch PC register.
- The fetch PC SHALL advance by 4 on each accepted request (imem_req_o & imem_ready_i), mod 2^32.
- 32'hFFFF_FFFC SHALL wrap to 0.
REQ-025 The PC of each accepted request SHALL be stored with it and pushed with its response as pc_o.
REQ-026 The response latency is 1 or more cycles. A response with imem_rvalid_i high SHALL be pushed into the FIFO in that cycle unless it is tagged stale (see REQ-028).
REQ-027 instr_valid_o SHALL be high exactly when the FIFO is non-empty.
- Pop occurs on instr_valid_o & instr_ready_i.
- instr_o and pc_o SHALL be held stable while instr_valid_o is high and instr_ready_i is low.
REQ-028 On redirect_i, at the clock edge:
- The FIFO SHALL be flushed.
- The fetch PC SHALL load redirect_pc_i.
- Any outstanding request SHALL be marked stale, and its response SHALL be discarded when it arrives.
- instr_valid_o SHALL be low in the following cycle.
REQ-029 Redirect priority SHALL be higher than a same-cycle push or pop. The decoder handshake on that cycle still completes: the word shown at the FIFO head is consumed.
REQ-030 If a redirect arrives while a stale request is outstanding, the new fetch SHALL be issued only after the stale response returns. This preserves the one-outstanding limit.
REQ-031 Simultaneous push and pop on a full FIFO SHALL be legal, and the count SHALL remain unchanged.
REQ-032 misalign_o SHALL be high in HALT and low otherwise; no requests SHALL be issued in HALT.

Reset
REQ-033 While reset is high, the following outputs SHALL be held low:
- imem_req_o
- instr_valid_o
- misalign_o
REQ-034 While reset is high, the following state SHALL be cleared or loaded:
- FIFO flushed.
- Outstanding and stale flags cleared.
- Fetch PC = RESET_PC.
- FSM = RESET.
REQ-035 Reset asserted mid-transaction SHALL abandon the outstanding request. A response arriving after reset deassertion without a matching request SHALL be ignored.
REQ-036 The first imem_req_o SHALL assert in the second cycle after reset deasserts, with imem_addr_o = RESET_PC.

Verification
REQ-037 Scenario "straight line":
- Stimulus: 1-cycle ROM latency, imem_ready_i=1, instr_ready_i=1.
- Required response: pc_o sequence 0,4,8,C, with instr_o matching ROM contents.
REQ-038 Scenario "backpressure":
- Stimulus: instr_ready_i=0 for 6 cycles.
- Required response: FIFO holds FIFO_DEPTH words; imem_req_o stays low; instr_o/pc_o stay stable; no word is lost after ready returns.
REQ-039 Scenario "redirect with in-flight fetch":
- Stimulus: redirect_pc_i=32'h40 while a request to 0x8 is outstanding with 3-cycle latency.
- Required response: the 0x8 word is discarded; the next delivered pc_o is 0x40.
REQ-040 Scenario "misaligned redirect":
- Stimulus: redirect to 32'h42.
- Required response: misalign_o=1 and no requests issued.
- Then a redirect to 32'h80 delivers pc_o=0x80 with misalign_o=0.
REQ-041 Scenario "wrap":
- Stimulus: redirect to 32'hFFFF_FFFC.
- Required response: pc_o sequence FFFF_FFFC, 0000_0000.
REQ-042 Scenario "reset mid-fetch":
- Stimulus: reset for 1 cycle while WAIT is active; the late response arrives after deassertion.
- Required response: the late response is ignored; the first delivered pc_o = RESET_PC.

Source files
------------

// File: rtl/rv32_ifu_if.sv
// Instruction-fetch handshake bundle: ROM request/response, EXU redirect and decoder port.
// master = fetch unit side, slave = environment (ROM, EXU, decoder) side.
interface rv32_ifu_if;
   logic        imem_req_o;
   logic        imem_ready_i;
   logic [31:0] imem_addr_o;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        misalign_o;

   modport master (
      output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, misalign_o,
      input  imem_ready_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, misalign_o,
      output imem_ready_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
   );
endinterface

// File: rtl/rv32_ifu.sv
// RV32 instruction fetch unit: one outstanding ROM request, small instruction FIFO,
// redirect with stale-response discard, halt on misaligned redirect target.
module rv32_ifu #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input logic        clk,
   input logic        reset,
   rv32_ifu_if.master bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_L = CW'(FIFO_DEPTH);

   // state | meaning
   // RESET | in reset or first cycle after it, no fetch yet
   // FETCH | may issue a request (held off while a stale one is pending)
   // WAIT  | one live request outstanding, waiting for rvalid
   // HALT  | last redirect target misaligned, fetch stopped
   typedef enum logic [1:0] {ST_RESET, ST_FETCH, ST_WAIT, ST_HALT} state_e;

   state_e        state_q, state_d;
   logic [31:0]   pc_q, pc_d, req_pc_q, req_pc_d;
   logic          out_q, out_d, stale_q, stale_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d, level;
   logic [63:0]   mem_q [FIFO_DEPTH];
   logic          valid, pop, rsp, push, req, accept, misaligned;

   always_comb begin
      misaligned = bus.redirect_pc_i[1:0] != 2'b00;
      valid      = (count_q != '0) && !reset;
      pop        = valid && bus.instr_ready_i;
      rsp        = bus.imem_rvalid_i && out_q;
      push       = rsp && !stale_q && !bus.redirect_i;
      level      = count_q + CW'(out_q);
      req        = (state_q == ST_FETCH) && !out_q && ((level < DEPTH_L) || pop) && !reset;
      accept     = req && bus.imem_ready_i;

      state_d = state_q;
      case (state_q)
         ST_RESET: state_d = ST_FETCH;
         ST_FETCH: if (accept) state_d = ST_WAIT;
         ST_WAIT:  if (bus.imem_rvalid_i) state_d = ST_FETCH;
         ST_HALT:  state_d = ST_HALT;
         default:  state_d = ST_RESET;
      endcase
      if (bus.redirect_i) state_d = misaligned ? ST_HALT : ST_FETCH;

      pc_d     = bus.redirect_i ? bus.redirect_pc_i : (accept ? pc_q + 32'd4 : pc_q);
      req_pc_d = accept ? pc_q : req_pc_q;
      // A request accepted in the redirect cycle itself is also stale.
      out_d    = (out_q && !bus.imem_rvalid_i) || accept;
      stale_d  = out_d && (stale_q || bus.redirect_i);

      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (bus.redirect_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_RESET;
         pc_q     <= RESET_PC;
         req_pc_q <= RESET_PC;
         out_q    <= 1'b0;
         stale_q  <= 1'b0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         out_q    <= out_d;
         stale_q  <= stale_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {req_pc_q, bus.imem_rdata_i};
   end

   assign bus.imem_req_o    = req;
   assign bus.imem_addr_o   = pc_q;
   assign bus.instr_valid_o = valid;
   assign bus.instr_o       = mem_q[rd_ptr_q][31:0];
   assign bus.pc_o          = mem_q[rd_ptr_q][63:32];
   assign bus.misalign_o    = (state_q == ST_HALT) && !reset;
endmodule

// File: tb/tb_rv32_ifu.sv
// Bench for rv32_ifu: ROM responder with variable latency and a reference model that
// expects delivered PCs to run sequentially from the last redirect/reset target.
module tb_rv32_ifu;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rv32_ifu_if bus ();
   rv32_ifu #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_cmp = 0;
   int n_err = 0;

   logic        rom_busy = 1'b0;
   logic [31:0] rom_addr = '0;
   int          rom_cnt  = 0;
   int          lat_cfg  = 1;

   logic acc, pop, rsp;
   logic [31:0] exp_pc;
   logic        halted;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Apply inputs just after the falling edge, then observe what the next rising edge will see.
   task automatic drive(input logic rst, input logic rdy, input logic irdy,
                        input logic redir, input logic [31:0] rpc);
      reset             = rst;
      bus.imem_ready_i  = rdy;
      bus.instr_ready_i = irdy;
      bus.redirect_i    = redir;
      bus.redirect_pc_i = rpc;
      bus.imem_rvalid_i = rom_busy && rom_cnt == 0;
      bus.imem_rdata_i  = (rom_busy && rom_cnt == 0) ? rom_word(rom_addr) : $urandom;
      #1;
      acc = bus.imem_req_o & bus.imem_ready_i;
      pop = bus.instr_valid_o & bus.instr_ready_i;
      rsp = bus.imem_rvalid_i;
   endtask

   task automatic advance();
      logic [31:0] a;
      a = bus.imem_addr_o;
      @(posedge clk);
      if (rsp) rom_busy = 1'b0;
      if (acc) begin
         rom_busy = 1'b1;
         rom_addr = a;
         rom_cnt  = (lat_cfg == 0 ? int'($urandom_range(3, 1)) : lat_cfg) - 1;
      end else if (rom_busy && rom_cnt > 0) begin
         rom_cnt = rom_cnt - 1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rom_busy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
         advance();
      end
      exp_pc = RESET_PC;
      halted = 1'b0;
   endtask

   task automatic test_reset();
      rom_busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
         n_cmp++;
         if ({bus.imem_req_o, bus.instr_valid_o, bus.misalign_o} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_outputs: req/valid/misalign=%b required 000", {bus.imem_req_o, bus.instr_valid_o, bus.misalign_o});
         end
         advance();
      end
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (bus.imem_req_o !== 1'b0) begin
         n_err++;
         $display("FAIL first_cycle_no_req: req=%b required 0", bus.imem_req_o);
      end
      advance();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== RESET_PC) begin
         n_err++;
         $display("FAIL first_req: req=%b addr=%h required 1 %h", bus.imem_req_o, bus.imem_addr_o, RESET_PC);
      end
      advance();
   endtask

   task automatic test_straight_line();
      int got = 0;
      do_reset();
      lat_cfg = 1;
      for (int c = 0; c < 40 && got < 4; c++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
         if (acc) begin
            n_cmp++;
            if (rom_busy && !rsp) begin n_err++; $display("FAIL straight_one_outstanding: second request while busy"); end
         end
         if (pop) begin
            n_cmp++;
            if (bus.pc_o !== RESET_PC + 32'(got * 4) || bus.instr_o !== rom_word(RESET_PC + 32'(got * 4))) begin
               n_err++;
               $display("FAIL straight_pc: pc=%h instr=%h required %h %h", bus.pc_o, bus.instr_o,
                        RESET_PC + 32'(got * 4), rom_word(RESET_PC + 32'(got * 4)));
            end
            got++;
         end
         advance();
      end
      n_cmp++;
      if (got != 4) begin n_err++; $display("FAIL straight_timeout: delivered %0d required 4", got); end
   endtask

   task automatic test_backpressure();
      int got = 0;
      do_reset();
      lat_cfg = 1;
      for (int c = 0; c < 14; c++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
         if (c >= 8) begin
            n_cmp++;
            if (bus.imem_req_o !== 1'b0 || bus.instr_valid_o !== 1'b1 || bus.pc_o !== RESET_PC ||
                bus.instr_o !== rom_word(RESET_PC)) begin
               n_err++;
               $display("FAIL bp_hold: req=%b valid=%b pc=%h instr=%h required 0 1 %h %h", bus.imem_req_o,
                        bus.instr_valid_o, bus.pc_o, bus.instr_o, RESET_PC, rom_word(RESET_PC));
            end
         end
         advance();
      end
      lat_cfg = 3;
      for (int c = 0; c < 40 && got < DEPTH + 2; c++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
         if (c < DEPTH) begin
            n_cmp++;
            if (bus.instr_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_buffered: valid=%b required 1 at release cycle %0d", bus.instr_valid_o, c); end
         end
         if (pop) begin
            n_cmp++;
            if (bus.pc_o !== exp_pc || bus.instr_o !== rom_word(exp_pc)) begin
               n_err++;
               $display("FAIL bp_order: pc=%h instr=%h required %h %h", bus.pc_o, bus.instr_o, exp_pc, rom_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
            got++;
         end
         advance();
      end
      n_cmp++;
      if (got != DEPTH + 2) begin n_err++; $display("FAIL bp_timeout: delivered %0d required %0d", got, DEPTH + 2); end
   endtask

   task automatic test_redirect_inflight();
      logic seen = 1'b0;
      logic done = 1'b0;
      do_reset();
      lat_cfg = 3;
      for (int c = 0; c < 60 && !seen; c++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
         if (pop) begin
            n_cmp++;
            if (bus.pc_o !== exp_pc) begin n_err++; $display("FAIL inflight_pre: pc=%h required %h", bus.pc_o, exp_pc); end
            exp_pc = exp_pc + 32'd4;
         end
         if (acc && bus.imem_addr_o == 32'h8) seen = 1'b1;
         advance();
      end
      n_cmp++;
      if (!seen) begin n_err++; $display("FAIL inflight_req8: request to 8 seen=%b required 1", seen); end
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
      exp_pc = 32'h40;
      advance();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (bus.instr_valid_o !== 1'b0) begin n_err++; $display("FAIL inflight_flush: valid=%b required 0", bus.instr_valid_o); end
      for (int c = 0; c < 40 && !done; c++) begin
         if (c > 0) drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
         if (acc) begin
            n_cmp++;
            if (rom_busy && !rsp) begin n_err++; $display("FAIL inflight_one_outstanding: request while stale busy"); end
         end
         if (pop) begin
            n_cmp++;
            if (bus.pc_o !== 32'h40 || bus.instr_o !== rom_word(32'h40)) begin
               n_err++;
               $display("FAIL inflight_target: pc=%h instr=%h required 00000040 %h", bus.pc_o, bus.instr_o, rom_word(32'h40));
            end
            done = 1'b1;
         end
         advance();
      end
      n_cmp++;
      if (!done) begin n_err++; $display("FAIL inflight_timeout: delivered=%b required 1", done); end
   endtask

   task automatic test_misaligned();
      logic done = 1'b0;
      do_reset();
      lat_cfg = 1;
      for (int c = 0; c < 6; c++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
         advance();
      end
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h42);
      advance();
      for (int c = 0; c < 8; c++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
         n_cmp++;
         if (bus.misalign_o !== 1'b1 || bus.imem_req_o !== 1'b0 || bus.instr_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL halt_state: misalign=%b req=%b valid=%b required 1 0 0", bus.misalign_o, bus.imem_req_o, bus.instr_valid_o);
         end
         advance();
      end
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h80);
      advance();
      for (int c = 0; c < 20 && !done; c++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
         n_cmp++;
         if (bus.misalign_o !== 1'b0) begin n_err++; $display("FAIL halt_exit: misalign=%b required 0", bus.misalign_o); end
         if (pop) begin
            n_cmp++;
            if (bus.pc_o !== 32'h80 || bus.instr_o !== rom_word(32'h80)) begin
               n_err++;
               $display("FAIL halt_target: pc=%h required 00000080", bus.pc_o);
            end
            done = 1'b1;
         end
         advance();
      end
      n_cmp++;
      if (!done) begin n_err++; $display("FAIL halt_timeout: delivered=%b required 1", done); end
   endtask

   task automatic test_wrap();
      int got = 0;
      logic [31:0] want;
      do_reset();
      lat_cfg = 2;
      for (int c = 0; c < 4; c++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
         advance();
      end
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
      advance();
      for (int c = 0; c < 40 && got < 2; c++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
         if (pop) begin
            want = (got == 0) ? 32'hFFFF_FFFC : 32'h0000_0000;
            n_cmp++;
            if (bus.pc_o !== want || bus.instr_o !== rom_word(want)) begin
               n_err++;
               $display("FAIL wrap_pc: pc=%h instr=%h required %h %h", bus.pc_o, bus.instr_o, want, rom_word(want));
            end
            got++;
         end
         advance();
      end
      n_cmp++;
      if (got != 2) begin n_err++; $display("FAIL wrap_timeout: delivered %0d required 2", got); end
   endtask

   task automatic test_reset_mid_fetch();
      logic seen = 1'b0;
      logic late = 1'b0;
      logic done = 1'b0;
      do_reset();
      lat_cfg = 3;
      for (int c = 0; c < 60 && !seen; c++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
         if (acc && bus.imem_addr_o == RESET_PC + 32'h8) seen = 1'b1;
         advance();
      end
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (bus.imem_req_o !== 1'b0 || bus.instr_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_outputs: req=%b valid=%b required 0 0", bus.imem_req_o, bus.instr_valid_o);
      end
      advance();
      for (int c = 0; c < 40 && !done; c++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
         if (rsp && rom_addr == RESET_PC + 32'h8) late = 1'b1;
         if (pop) begin
            n_cmp++;
            if (bus.pc_o !== RESET_PC || bus.instr_o !== rom_word(RESET_PC)) begin
               n_err++;
               $display("FAIL midreset_first: pc=%h instr=%h required %h %h", bus.pc_o, bus.instr_o, RESET_PC, rom_word(RESET_PC));
            end
            done = 1'b1;
         end
         advance();
      end
      n_cmp++;
      if (!(seen && late && done)) begin
         n_err++;
         $display("FAIL midreset_scenario: req8=%b late_rsp=%b delivered=%b required 111", seen, late, done);
      end
   endtask

   task automatic test_random();
      logic        irdy, redir, prev_redir, prev_hold;
      logic [31:0] rpc, prev_pc, prev_instr;
      int          pops = 0;
      do_reset();
      lat_cfg    = 0;
      prev_redir = 1'b0;
      prev_hold  = 1'b0;
      prev_pc    = '0;
      prev_instr = '0;
      for (int c = 0; c < 800; c++) begin
         irdy  = ($urandom % 3) != 0;
         redir = $urandom_range(0, 29) == 0;
         rpc   = $urandom;
         if (($urandom % 4) != 0) rpc[1:0] = 2'b00;
         drive(1'b0, ($urandom % 4) != 0, irdy, redir, rpc);
         n_cmp++;
         if (bus.misalign_o !== halted || (halted && bus.imem_req_o !== 1'b0)) begin
            n_err++;
            $display("FAIL rand_halt: misalign=%b req=%b required %b", bus.misalign_o, bus.imem_req_o, halted);
         end
         if (prev_redir) begin
            n_cmp++;
            if (bus.instr_valid_o !== 1'b0) begin n_err++; $display("FAIL rand_flush: valid=%b required 0", bus.instr_valid_o); end
         end
         if (prev_hold) begin
            n_cmp++;
            if (bus.instr_valid_o !== 1'b1 || bus.pc_o !== prev_pc || bus.instr_o !== prev_instr) begin
               n_err++;
               $display("FAIL rand_stable: pc=%h instr=%h required %h %h", bus.pc_o, bus.instr_o, prev_pc, prev_instr);
            end
         end
         if (acc) begin
            n_cmp++;
            if ((rom_busy && !rsp) || bus.imem_addr_o[1:0] !== 2'b00) begin
               n_err++;
               $display("FAIL rand_request: busy=%b addr=%h required idle and aligned", rom_busy && !rsp, bus.imem_addr_o);
            end
         end
         if (pop) begin
            n_cmp++;
            if (bus.pc_o !== exp_pc || bus.instr_o !== rom_word(exp_pc)) begin
               n_err++;
               $display("FAIL rand_pop: pc=%h instr=%h required %h %h", bus.pc_o, bus.instr_o, exp_pc, rom_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
            pops++;
         end
         prev_hold  = bus.instr_valid_o && !irdy && !redir;
         prev_pc    = bus.pc_o;
         prev_instr = bus.instr_o;
         prev_redir = redir;
         if (redir) begin
            exp_pc = rpc;
            halted = rpc[1:0] != 2'b00;
         end
         advance();
      end
      n_cmp++;
      if (pops < 50) begin n_err++; $display("FAIL rand_progress: delivered %0d required at least 50", pops); end
   endtask

   initial begin
      test_reset();
      test_straight_line();
      test_backpressure();
      test_redirect_inflight();
      test_misaligned();
      test_wrap();
      test_reset_mid_fetch();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
